dsram_confreg_responder: RTL and testbench



---
 rtl/dsram_confreg_responder.sv | 138 +++++++++++++
 tb/tb_dsram_confreg_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_confreg_responder.sv
`default_nettype none
// ============================================================================
// Module   : dsram_confreg_responder
// Purpose  : Data-SRAM port target for the core. Decodes a 64 KiB window
//            into a scratch word RAM and a bank of config registers
//            (LED, NUM, SWITCH, TIMER, SIMU). Reads return one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module dsram_confreg_responder #(
    parameter logic [15:0] BASE_HI   = 16'hbfaf,
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] SIMU_FLAG = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led,
    output logic [31:0] num
);

    localparam int DEPTH = 1 << RAM_AW;

    // Register offsets expressed as word addresses (addr[15:2])
    localparam logic [13:0] OFF_LED   = 14'h3C00;
    localparam logic [13:0] OFF_NUM   = 14'h3C01;
    localparam logic [13:0] OFF_SW    = 14'h3C02;
    localparam logic [13:0] OFF_TIMER = 14'h3C03;
    localparam logic [13:0] OFF_SIMU  = 14'h3C04;

    logic [31:0]       ram [DEPTH];
    logic [15:0]       led_reg;
    logic [31:0]       num_reg;
    logic [31:0]       timer_reg;
    logic [7:0]        sw_sync1;
    logic [7:0]        sw_sync2;

    logic              hit;
    logic              is_ram;
    logic              wr_hit;
    logic              rd_req;
    logic [13:0]       reg_off;
    logic [RAM_AW-1:0] word_idx;
    logic [31:0]       rd_word;
    logic [31:0]       reg_cur;
    logic [31:0]       reg_merged;
    logic              addr_lsb_unused;

    // Byte-lane replace: lanes with a set enable take the new data
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign hit             = sram_en && (sram_addr[31:16] == BASE_HI);
    assign is_ram          = (sram_addr[15:12] != 4'hF);
    assign reg_off         = sram_addr[15:2];
    assign word_idx        = sram_addr[RAM_AW+1:2];
    assign wr_hit          = hit && (sram_wen != 4'h0);
    // Any read request updates rdata; a miss loads zero
    assign rd_req          = sram_en && (sram_wen == 4'h0);
    assign addr_lsb_unused = ^sram_addr[1:0];

    // Read-data mux and write-merge source for the addressed word
    always_comb begin
        rd_word = 32'h0;
        reg_cur = 32'h0;
        case (reg_off)
            OFF_LED:   reg_cur = {16'h0, led_reg};
            OFF_NUM:   reg_cur = num_reg;
            OFF_SW:    reg_cur = {24'h0, sw_sync2};
            OFF_TIMER: reg_cur = timer_reg;
            OFF_SIMU:  reg_cur = SIMU_FLAG;
            default:   reg_cur = 32'h0;
        endcase
        if (hit) begin
            rd_word = is_ram ? ram[word_idx] : reg_cur;
        end
    end

    assign reg_merged = byte_merge(reg_cur, sram_wdata, sram_wen);

    // Scratch RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (resetn && wr_hit && is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_wen[i]) ram[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
        end
    end

    // Config registers, free-running timer and switch synchronizer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_reg   <= 16'h0;
            num_reg   <= 32'h0;
            timer_reg <= 32'h0;
            sw_sync1  <= 8'h0;
            sw_sync2  <= 8'h0;
        end else begin
            sw_sync1  <= switch_in;
            sw_sync2  <= sw_sync1;
            timer_reg <= timer_reg + 32'd1;
            if (wr_hit && !is_ram) begin
                case (reg_off)
                    OFF_LED:   led_reg   <= reg_merged[15:0];
                    OFF_NUM:   num_reg   <= reg_merged;
                    OFF_TIMER: timer_reg <= reg_merged;
                    default:   ;
                endcase
            end
        end
    end

    // Read response register: loads on reads only, holds otherwise
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sram_rdata <= 32'h0;
        end else if (rd_req) begin
            sram_rdata <= rd_word;
        end
    end

    assign led = led_reg;
    assign num = num_reg;

endmodule
`default_nettype wire

// File: tb/tb_dsram_confreg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsram_confreg_responder
// Purpose  : Scoreboard bench for dsram_confreg_responder; directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsram_confreg_responder;

    localparam logic [15:0] BASE  = 16'hbfaf;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_wen = 4'h0;
    logic [31:0] sram_addr = 32'h0;
    logic [31:0] sram_wdata = 32'h0;
    logic [31:0] sram_rdata;
    logic [7:0]  switch_in = 8'h0;
    logic [15:0] led;
    logic [31:0] num;

    always #5 clk = ~clk;

    dsram_confreg_responder #(
        .BASE_HI  (16'hbfaf),
        .RAM_AW   (10),
        .SIMU_FLAG(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sram_en   (sram_en),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .switch_in (switch_in),
        .led       (led),
        .num       (num)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_ram [DEPTH];
    logic [15:0] m_led = 16'h0;
    logic [31:0] m_num = 32'h0;
    logic [31:0] m_timer = 32'h0;
    logic [7:0]  m_s1 = 8'h0;
    logic [7:0]  m_s2 = 8'h0;

    // Scoreboard of expected rdata updates
    logic [31:0] exp_q[$];
    string       name_q[$];
    bit          mon_on = 1'b0;
    logic [31:0] last_rd = 32'h0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // One clock cycle: drive at negedge, advance the model at posedge
    task automatic cyc(input logic rn, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input string nm = "rand_read", input bit use_c = 1'b0,
                       input logic [31:0] c = 32'h0);
        logic [31:0] rv;
        logic [31:0] tnext;
        logic [31:0] tmp;
        logic        hit;
        logic [15:0] off;
        int          idx;
        resetn = rn; sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wd;
        @(posedge clk);
        hit = en && (addr[31:16] == BASE);
        off = {addr[15:2], 2'b00};
        idx = int'(addr[15:2]) % DEPTH;
        rv  = 32'h0;
        if (hit) begin
            if (off < 16'hF000) rv = m_ram[idx];
            else begin
                case (off)
                    16'hF000: rv = {16'h0, m_led};
                    16'hF004: rv = m_num;
                    16'hF008: rv = {24'h0, m_s2};
                    16'hF00C: rv = m_timer;
                    16'hF010: rv = 32'h0;
                    default:  rv = 32'h0;
                endcase
            end
        end
        if (!rn) begin
            m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0; m_s1 = 8'h0; m_s2 = 8'h0;
            exp_q.push_back(32'h0); name_q.push_back("reset_rdata");
            mon_on = 1'b1;
        end else begin
            tnext = m_timer + 32'd1;
            m_s2  = m_s1;
            m_s1  = switch_in;
            if (hit && wen != 4'h0) begin
                if (off < 16'hF000) m_ram[idx] = merge(m_ram[idx], wd, wen);
                else if (off == 16'hF000) begin
                    tmp = merge({16'h0, m_led}, wd, wen);
                    m_led = tmp[15:0];
                end
                else if (off == 16'hF004) m_num = merge(m_num, wd, wen);
                else if (off == 16'hF00C) tnext = merge(m_timer, wd, wen);
            end
            m_timer = tnext;
            if (en && wen == 4'h0) begin
                exp_q.push_back(use_c ? c : rv);
                name_q.push_back(nm);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Monitor: pops one expectation per rdata update, else rdata must hold
    always @(negedge clk) begin
        if (mon_on) begin
            if (exp_q.size() > 0) begin
                last_rd = exp_q.pop_front();
                chk(name_q.pop_front(), sram_rdata, last_rd);
            end else begin
                chk("rdata_hold", sram_rdata, last_rd);
            end
            chk("led_out", {16'h0, led}, {16'h0, m_led});
            chk("num_out", num, m_num);
        end
    end

    // Stimulus
    initial begin
        logic [31:0] a;
        logic [15:0] hi;
        int          r;
        @(negedge clk);
        repeat (3) cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 4'hF, {BASE, 16'(i * 4)}, $urandom);
        repeat (2) cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Timer starts at 0 right after reset and counts every cycle
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF00C}, 32'h0, "timer_first", 1'b1, 32'd0);
        idle(9);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF00C}, 32'h0, "timer_plus10", 1'b1, 32'd10);

        // Byte-lane merge in RAM
        cyc(1'b1, 1'b1, 4'hF,    {BASE, 16'h0010}, 32'h11223344);
        cyc(1'b1, 1'b1, 4'b0010, {BASE, 16'h0010}, 32'hAABBCCDD);
        cyc(1'b1, 1'b1, 4'h0,    {BASE, 16'h0010}, 32'h0, "ram_byte_merge", 1'b1, 32'h1122CC44);

        // Aliasing and out-of-window accesses
        cyc(1'b1, 1'b1, 4'hF, {BASE, 16'h0000}, 32'hDEADBEEF);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'h1000}, 32'h0, "ram_alias", 1'b1, 32'hDEADBEEF);
        cyc(1'b1, 1'b1, 4'h0, 32'hbfbf0000, 32'h0, "nohit_read", 1'b1, 32'h0);
        cyc(1'b1, 1'b1, 4'hF, 32'hbfbf0000, 32'h12345678);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'h0000}, 32'h0, "nohit_write_ignored", 1'b1, 32'hDEADBEEF);

        // LED and NUM registers
        cyc(1'b1, 1'b1, 4'hF, {BASE, 16'hF000}, 32'hFFFF1234);
        chk("led_after_write", {16'h0, led}, 32'h0000_1234);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF000}, 32'h0, "led_readback", 1'b1, 32'h0000_1234);
        cyc(1'b1, 1'b1, 4'b1100, {BASE, 16'hF004}, 32'h87654321);
        chk("num_partial_write", num, 32'h8765_0000);

        // Timer write and wrap
        cyc(1'b1, 1'b1, 4'hF, {BASE, 16'hF00C}, 32'h0000_0100);
        idle(3);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF00C}, 32'h0, "timer_after_write", 1'b1, 32'h0000_0103);
        cyc(1'b1, 1'b1, 4'hF, {BASE, 16'hF00C}, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF00C}, 32'h0, "timer_max", 1'b1, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF00C}, 32'h0, "timer_wrap", 1'b1, 32'h0);

        // Switch synchronizer latency
        switch_in = 8'hA5;
        idle(1);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF008}, 32'h0, "switch_early", 1'b1, 32'h0);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF008}, 32'h0, "switch_synced", 1'b1, 32'h0000_00A5);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF010}, 32'h0, "simu_flag", 1'b1, 32'h0);

        // Reset in the middle of a read burst; requests during reset are dropped
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'h0000}, 32'h0, "burst_ram0", 1'b1, 32'hDEADBEEF);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF000}, 32'h0, "burst_led", 1'b1, 32'h0000_1234);
        cyc(1'b0, 1'b1, 4'h0, {BASE, 16'hF00C}, 32'h0);
        cyc(1'b0, 1'b1, 4'hF, {BASE, 16'h0000}, 32'h0);
        chk("led_cleared", {16'h0, led}, 32'h0);
        chk("num_cleared", num, 32'h0);
        idle(1);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'hF00C}, 32'h0, "timer_cleared", 1'b1, 32'd1);
        cyc(1'b1, 1'b1, 4'h0, {BASE, 16'h0000}, 32'h0, "ram_survives_reset", 1'b1, 32'hDEADBEEF);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) switch_in = 8'($urandom);
            r = int'($urandom_range(0, 9));
            if (r <= 4)      a = {BASE, 16'($urandom_range(0, 16'hEFFF))};
            else if (r <= 7) a = {BASE, 16'(16'hF000 + 4 * $urandom_range(0, 4))};
            else if (r == 8) a = {BASE, 16'(16'hF014 + $urandom_range(0, 16'h0FEB))};
            else begin
                hi = 16'($urandom);
                if (hi == BASE) hi = ~hi;
                a = {hi, 16'($urandom)};
            end
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
                a, $urandom);
        end

        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
